// File: rtl/sram_synaptic_arbiter.sv
// sram_synaptic_arbiter: owns the single-port synaptic weight SRAM and shares it
// between the inference datapath (pipelined reads) and the FF-STDP learning
// engine (read-modify-write with a saturating signed update in each weight lane).
//
// Ports
//   CK, RST                     clock, synchronous active-high reset
//   INF_REQ/INF_ADDR            inference read request (held until INF_GNT)
//   INF_GNT                     inference grant pulse (address sampled)
//   INF_RVALID/INF_RDATA        read data, one cycle after INF_GNT
//   LRN_REQ/LRN_ADDR/LRN_DELTA  learning RMW request (held until LRN_GNT)
//   LRN_GNT                     learning grant pulse (address/delta captured)
//   LRN_DONE                    write-back issued (or skipped) pulse
//   SRAM_CS/WE/A/D, SRAM_Q      SRAM macro interface, 1-cycle registered read
//
// Build option: define SYN_ARB_ZERO_SKIP_EN to let an all-zero delta complete at
// grant time with no SRAM access.
module sram_synaptic_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned STARVE_MAX   = 4
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  INF_REQ,
    input  logic [ADDR_WIDTH-1:0] INF_ADDR,
    output logic                  INF_GNT,
    output logic                  INF_RVALID,
    output logic [DATA_WIDTH-1:0] INF_RDATA,
    input  logic                  LRN_REQ,
    input  logic [ADDR_WIDTH-1:0] LRN_ADDR,
    input  logic [DATA_WIDTH-1:0] LRN_DELTA,
    output logic                  LRN_GNT,
    output logic                  LRN_DONE,
    output logic                  SRAM_CS,
    output logic                  SRAM_WE,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
);

    localparam int unsigned LANES = DATA_WIDTH / WEIGHT_WIDTH;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

`ifdef SYN_ARB_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RMW_RD_WAIT,
        ST_RMW_WR
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        starve_q;
    logic                    inf_rvalid_q;
    logic [ADDR_WIDTH-1:0]   lrn_addr_q;
    logic [DATA_WIDTH-1:0]   lrn_delta_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   sat_word;

    logic                    starve_full;
    logic                    lrn_zero;
    logic                    inf_gnt;
    logic                    lrn_gnt;
    logic                    lrn_done;
    logic                    cs;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;

    assign starve_full = (starve_q == CNT_W'(STARVE_MAX));
    assign lrn_zero    = (LRN_DELTA == '0);

    // Signed add of one weight lane, clamped to the representable range.
    function automatic logic [WEIGHT_WIDTH-1:0] sat_add(
        input logic [WEIGHT_WIDTH-1:0] w,
        input logic [WEIGHT_WIDTH-1:0] d
    );
        logic [WEIGHT_WIDTH:0] s;
        s = {w[WEIGHT_WIDTH-1], w} + {d[WEIGHT_WIDTH-1], d};
        if (s[WEIGHT_WIDTH] != s[WEIGHT_WIDTH-1]) begin
            sat_add = s[WEIGHT_WIDTH] ? {1'b1, {(WEIGHT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
        end else begin
            sat_add = s[WEIGHT_WIDTH-1:0];
        end
    endfunction

    // Per-lane saturating update of the word returned by the RMW read.
    always_comb begin
        sat_word = '0;
        for (int l = 0; l < LANES; l++) begin
            sat_word[l*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                sat_add(SRAM_Q[l*WEIGHT_WIDTH +: WEIGHT_WIDTH],
                        lrn_delta_q[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        end
    end

    // Arbitration, next state and SRAM strobes; everything is held off while RST
    // is high so a reset cycle can never start an access or issue a write.
    always_comb begin
        state_d  = state_q;
        inf_gnt  = 1'b0;
        lrn_gnt  = 1'b0;
        lrn_done = 1'b0;
        cs       = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        if (!RST) begin
            case (state_q)
                ST_IDLE: begin
                    if (LRN_REQ && (!INF_REQ || starve_full)) begin
                        lrn_gnt = 1'b1;
                        if (ZERO_SKIP && lrn_zero) begin
                            lrn_done = 1'b1;
                        end else begin
                            cs      = 1'b1;
                            addr    = LRN_ADDR;
                            state_d = ST_RMW_RD_WAIT;
                        end
                    end else if (INF_REQ) begin
                        inf_gnt = 1'b1;
                        cs      = 1'b1;
                        addr    = INF_ADDR;
                    end
                end
                ST_RMW_RD_WAIT: begin
                    state_d = ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    cs       = 1'b1;
                    we       = 1'b1;
                    addr     = lrn_addr_q;
                    wdata    = wdata_q;
                    lrn_done = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, starvation counter, read-valid pipe and RMW capture registers.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            inf_rvalid_q <= 1'b0;
            lrn_addr_q   <= '0;
            lrn_delta_q  <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            inf_rvalid_q <= inf_gnt;
            if (lrn_gnt) begin
                lrn_addr_q  <= LRN_ADDR;
                lrn_delta_q <= LRN_DELTA;
            end
            if (state_q == ST_RMW_RD_WAIT) begin
                wdata_q <= sat_word;
            end
            if (lrn_gnt || !LRN_REQ) begin
                starve_q <= '0;
            end else if (inf_gnt && !starve_full) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end

    assign INF_GNT    = inf_gnt;
    assign INF_RVALID = inf_rvalid_q;
    assign INF_RDATA  = inf_rvalid_q ? SRAM_Q : '0;
    assign LRN_GNT    = lrn_gnt;
    assign LRN_DONE   = lrn_done;
    assign SRAM_CS    = cs;
    assign SRAM_WE    = we;
    assign SRAM_A     = addr;
    assign SRAM_D     = wdata;

endmodule

// File: tb/tb_sram_synaptic_arbiter.sv
// Self-checking bench for sram_synaptic_arbiter: behavioural SRAM, a reference
// memory with a read/write scoreboard, a table of RMW vectors and hand-written
// sequences for arbitration, RMW timing, reset abort and zero-delta handling.
module tb_sram_synaptic_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          CK = 1'b0;
    logic          RST;
    logic          INF_REQ;
    logic [AW-1:0] INF_ADDR;
    logic          INF_GNT;
    logic          INF_RVALID;
    logic [DW-1:0] INF_RDATA;
    logic          LRN_REQ;
    logic [AW-1:0] LRN_ADDR;
    logic [DW-1:0] LRN_DELTA;
    logic          LRN_GNT;
    logic          LRN_DONE;
    logic          SRAM_CS;
    logic          SRAM_WE;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_D;
    logic [DW-1:0] SRAM_Q;

    always #5 CK = ~CK;

    sram_synaptic_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(8), .STARVE_MAX(4)
    ) dut (
        .CK(CK), .RST(RST),
        .INF_REQ(INF_REQ), .INF_ADDR(INF_ADDR), .INF_GNT(INF_GNT),
        .INF_RVALID(INF_RVALID), .INF_RDATA(INF_RDATA),
        .LRN_REQ(LRN_REQ), .LRN_ADDR(LRN_ADDR), .LRN_DELTA(LRN_DELTA),
        .LRN_GNT(LRN_GNT), .LRN_DONE(LRN_DONE),
        .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A),
        .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
    );

    // Behavioural SRAM with a backdoor preload port.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] q_r = '0;
    logic          pl_en;
    logic [AW-1:0] pl_a;
    logic [DW-1:0] pl_d;

    always @(posedge CK) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (SRAM_CS && SRAM_WE) mem[SRAM_A] <= SRAM_D;
        if (SRAM_CS && !SRAM_WE) q_r <= mem[SRAM_A];
    end
    assign SRAM_Q = q_r;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Independent lane-wise saturating model.
    function automatic logic [31:0] ref_sat(input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        int s;
        for (int l = 0; l < 4; l++) begin
            s = int'($signed(w[l*8 +: 8])) + int'($signed(d[l*8 +: 8]));
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            r[l*8 +: 8] = 8'(s);
        end
        return r;
    endfunction

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] rd_q [$];
    wr_t           wr_q [$];

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge CK) begin
        wr_t w;
        if (pl_en) ref_mem[pl_a] = pl_d;
        if (RST) begin
            rd_q.delete();
            wr_q.delete();
        end else begin
            check("gnt_exclusive", 32'(INF_GNT && LRN_GNT), 32'd0);
            if (!SRAM_WE) check("d_zero_no_we", SRAM_D, 32'd0);
            if (INF_RVALID) begin
                if (rd_q.size() == 0) check("rvalid_unexpected", 32'(INF_RVALID), 32'd0);
                else check("inf_rdata", INF_RDATA, rd_q.pop_front());
            end
            if (INF_GNT) begin
                check("inf_strobe", 32'({SRAM_CS, SRAM_WE}), 32'b10);
                check("inf_addr", 32'(SRAM_A), 32'(INF_ADDR));
                rd_q.push_back(ref_mem[INF_ADDR]);
            end
`ifdef SYN_ARB_ZERO_SKIP_EN
            if (LRN_GNT && LRN_DELTA != 0) begin
`else
            if (LRN_GNT) begin
`endif
                check("lrn_rd_strobe", 32'({SRAM_CS, SRAM_WE}), 32'b10);
                w.addr = LRN_ADDR;
                w.data = ref_sat(ref_mem[LRN_ADDR], LRN_DELTA);
                wr_q.push_back(w);
            end
            if (SRAM_CS && SRAM_WE) begin
                check("done_with_we", 32'(LRN_DONE), 32'd1);
                if (wr_q.size() == 0) begin
                    check("we_unexpected", 32'(SRAM_WE), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(SRAM_A), 32'(w.addr));
                    check("wr_data", SRAM_D, w.data);
                    ref_mem[w.addr] = w.data;
                end
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(posedge CK); #1;
        pl_en = 1'b1; pl_a = a; pl_d = v;
        @(posedge CK); #1;
        pl_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({INF_GNT, INF_RVALID, LRN_GNT, LRN_DONE, SRAM_CS, SRAM_WE}), 32'd0);
        check({name, "_a"}, 32'(SRAM_A), 32'd0);
        check({name, "_d"}, SRAM_D, 32'd0);
        check({name, "_rdata"}, INF_RDATA, 32'd0);
    endtask

    // Issue one learning request; returns grant and done cycles (-1 if never seen).
    task automatic lrn_rmw(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int g, output int dn);
        @(posedge CK); #1;
        LRN_REQ = 1'b1; LRN_ADDR = a; LRN_DELTA = d;
        g = -1; dn = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge CK);
            if (LRN_GNT) begin
                g = cyc;
                if (LRN_DONE) dn = cyc;
                break;
            end
        end
        @(posedge CK); #1;
        LRN_REQ = 1'b0;
        check("lrn_gnt_seen", 32'(g >= 0), 32'd1);
        for (int n = 0; n < 20 && dn < 0 && g >= 0; n++) begin
            @(negedge CK);
            if (LRN_DONE) dn = cyc;
        end
        check("lrn_done_seen", 32'(dn >= 0), 32'd1);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] word;
        logic [DW-1:0] delta;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int g, dn, ninf;
        bit seen;

        vecs[0] = '{addr: 8'h40, word: 32'h7F80_0500, delta: 32'h05FB_0300, exp: 32'h7F80_0800};
        vecs[1] = '{addr: 8'h41, word: 32'h0102_0304, delta: 32'h0101_0101, exp: 32'h0203_0405};
        vecs[2] = '{addr: 8'h42, word: 32'h80FF_7F00, delta: 32'hFF01_0180, exp: 32'h8000_7F80};
        vecs[3] = '{addr: 8'h43, word: 32'h40C0_1020, delta: 32'h40C0_F0E0, exp: 32'h7F80_0000};

        RST = 1'b1; INF_REQ = 1'b0; INF_ADDR = '0;
        LRN_REQ = 1'b0; LRN_ADDR = '0; LRN_DELTA = '0;
        pl_en = 1'b0; pl_a = '0; pl_d = '0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        check_all_zero("reset_outputs");
        @(posedge CK); #1;
        RST = 1'b0;
        @(negedge CK);
        check_all_zero("idle_no_req");

        // Back-to-back inference reads.
        preload(8'h10, 32'hA000_0010);
        preload(8'h11, 32'hB111_0011);
        preload(8'h12, 32'hC222_0012);
        for (int i = 0; i < 3; i++) begin
            @(posedge CK); #1;
            INF_REQ = 1'b1; INF_ADDR = 8'h10 + 8'(i);
            @(negedge CK);
            check("t1_gnt", 32'(INF_GNT), 32'd1);
            if (i > 0) check("t1_rvalid", 32'(INF_RVALID), 32'd1);
        end
        @(posedge CK); #1;
        INF_REQ = 1'b0;
        @(negedge CK);
        check("t1_last_rvalid", 32'(INF_RVALID), 32'd1);
        check("t1_last_rdata", INF_RDATA, 32'hC222_0012);
        check("t1_gnt_off", 32'(INF_GNT), 32'd0);
        @(negedge CK);
        check("t1_rvalid_off", 32'(INF_RVALID), 32'd0);

        // Table of saturating RMW vectors.
        for (int i = 0; i < 4; i++) begin
            preload(vecs[i].addr, vecs[i].word);
            lrn_rmw(vecs[i].addr, vecs[i].delta, g, dn);
            check("tbl_done_latency", 32'(dn - g), 32'd2);
            @(posedge CK); #1;
            check("tbl_word", mem[vecs[i].addr], vecs[i].exp);
        end

        // Starvation limit with both requests held.
        preload(8'h30, 32'h0000_0000);
        preload(8'h31, 32'hDEAD_BEEF);
        @(posedge CK); #1;
        LRN_REQ = 1'b1; LRN_ADDR = 8'h30; LRN_DELTA = 32'h0101_0101;
        INF_REQ = 1'b1; INF_ADDR = 8'h31;
        ninf = 0; seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CK);
            if (LRN_GNT) begin seen = 1'b1; break; end
            if (INF_GNT) ninf++;
        end
        check("t3_lrn_gnt", 32'(seen), 32'd1);
        check("t3_inf_before_lrn", 32'(ninf), 32'd4);
        @(posedge CK); #1;
        LRN_REQ = 1'b0;
        @(negedge CK);
        check("t3_no_inf_rd_wait", 32'(INF_GNT), 32'd0);
        @(negedge CK);
        check("t3_no_inf_wr", 32'(INF_GNT), 32'd0);
        check("t3_done", 32'(LRN_DONE), 32'd1);
        @(negedge CK);
        check("t3_inf_resume", 32'(INF_GNT), 32'd1);
        @(posedge CK); #1;
        INF_REQ = 1'b0;
        @(posedge CK); #1;
        check("t3_word", mem[8'h30], 32'h0101_0101);

        // Read-after-RMW at grant+3.
        preload(8'h20, 32'h1020_3040);
        @(posedge CK); #1;
        LRN_REQ = 1'b1; LRN_ADDR = 8'h20; LRN_DELTA = 32'h0101_0101;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CK);
            if (LRN_GNT) begin seen = 1'b1; break; end
        end
        check("t4_lrn_gnt", 32'(seen), 32'd1);
        @(posedge CK); #1;
        LRN_REQ = 1'b0; INF_REQ = 1'b1; INF_ADDR = 8'h20;
        @(negedge CK);
        check("t4_no_gnt_g1", 32'(INF_GNT), 32'd0);
        @(negedge CK);
        check("t4_we_g2", 32'({SRAM_WE, INF_GNT}), 32'b10);
        @(negedge CK);
        check("t4_gnt_g3", 32'(INF_GNT), 32'd1);
        @(posedge CK); #1;
        INF_REQ = 1'b0;
        @(negedge CK);
        check("t4_rvalid", 32'(INF_RVALID), 32'd1);
        check("t4_rdata", INF_RDATA, 32'h1121_3141);

        // Reset while waiting for the RMW read.
        preload(8'h50, 32'hAABB_CCDD);
        @(posedge CK); #1;
        LRN_REQ = 1'b1; LRN_ADDR = 8'h50; LRN_DELTA = 32'h0101_0101;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CK);
            if (LRN_GNT) begin seen = 1'b1; break; end
        end
        check("t5_lrn_gnt", 32'(seen), 32'd1);
        @(posedge CK); #1;
        RST = 1'b1; LRN_REQ = 1'b0;
        @(negedge CK);
        check("t5_abort_cycle", 32'({SRAM_WE, LRN_DONE}), 32'd0);
        @(posedge CK); #1;
        @(negedge CK);
        check_all_zero("t5_after_reset");
        @(posedge CK); #1;
        RST = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge CK);
            check("t5_no_write", 32'({SRAM_WE, LRN_DONE}), 32'd0);
        end
        @(posedge CK); #1;
        check("t5_word_kept", mem[8'h50], 32'hAABB_CCDD);

        // Zero delta.
        preload(8'h60, 32'h1234_5678);
`ifdef SYN_ARB_ZERO_SKIP_EN
        @(posedge CK); #1;
        LRN_REQ = 1'b1; LRN_ADDR = 8'h60; LRN_DELTA = '0;
        @(negedge CK);
        check("t6_skip_gnt_done", 32'({LRN_GNT, LRN_DONE, SRAM_CS}), 32'b110);
        @(posedge CK); #1;
        LRN_REQ = 1'b0;
        @(negedge CK);
        check("t6_skip_idle", 32'({LRN_GNT, LRN_DONE, SRAM_CS, SRAM_WE}), 32'd0);
`else
        lrn_rmw(8'h60, 32'h0, g, dn);
        check("t6_full_rmw_latency", 32'(dn - g), 32'd2);
`endif
        @(posedge CK); #1;
        check("t6_word_same", mem[8'h60], 32'h1234_5678);

        repeat (3) @(posedge CK);
        #1;
        check("sb_rd_empty", 32'(rd_q.size()), 32'd0);
        check("sb_wr_empty", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
